mul_issue_ctrl: RTL

//  Issue/completion controller for the fixed-latency, non-stallable pipelined Multiplier.

---
 rtl/mul_issue_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/completion controller for a fixed-latency pipelined multiplier; optional stats via MUL_ISSUE_CTRL_STATS_EN.
// Latency: result visible on rsp_* MUL_LATENCY+1 cycles after issue; 1 result/cycle sustained.
// Backpressure: req_ready is credit-based (inflight + buffered < FIFO_DEPTH), so a result always has a slot.

// Circular result buffer; write happens at the edge, so a push is visible one cycle later.
// Latency: 1 cycle push-to-head. Backpressure: caller must not push when full (asserted).
module mul_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           push,
    input  logic [WIDTH-1:0]               pushDat,
    input  logic                           pop,
    output logic [WIDTH-1:0]               headDat,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             wrEn;
    logic             rdEn;

    function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wrEn  = push & ~full;
    assign rdEn  = pop & ~empty;

    // Head reads as zero when empty so the response outputs are clean after reset/flush.
    assign headDat = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) wrPtr <= incPtr(wrPtr);
            if (rdEn) rdPtr <= incPtr(rdPtr);
            count <= count + CNT_W'(wrEn) - CNT_W'(rdEn);
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn && !clr) mem[wrPtr] <= pushDat;
    end

    pushWhenFull: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !clr));
endmodule

// Issue/completion controller; operands driven combinationally on fire, tags tracked in a valid/tag shift pipe.
// Latency: issue at edge N, FIFO push at edge N+MUL_LATENCY, rsp_valid the cycle after.
// Backpressure: rsp_ready stalls the FIFO head; credits throttle req_ready so pushes never overflow.
module mul_issue_ctrl #(
    parameter int WIDTH       = 32,
    parameter int TAG_WIDTH   = 5,
    parameter int MUL_LATENCY = 5,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_multiplicand,
    input  logic [WIDTH-1:0]     req_multiplier,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplier,
    input  logic [WIDTH-1:0]     mul_result,
    input  logic                 mul_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_overflow,
    output logic [TAG_WIDTH-1:0] rsp_tag
`ifdef MUL_ISSUE_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int IF_W  = $clog2(MUL_LATENCY+1);

    typedef struct packed {
        logic [WIDTH-1:0]     result;
        logic                 overflow;
        logic [TAG_WIDTH-1:0] tag;
    } rspEntry_t;

    if (MUL_LATENCY < 1) begin : gBadLatency
        $error("MUL_LATENCY must be at least 1");
    end
    if (FIFO_DEPTH < MUL_LATENCY) begin : gBadDepth
        $error("FIFO_DEPTH must be >= MUL_LATENCY");
    end

    logic                 fire;
    logic                 push;
    logic                 pop;
    logic [MUL_LATENCY-1:0] pipeVld;
    logic [TAG_WIDTH-1:0] pipeTag [MUL_LATENCY];
    logic [IF_W-1:0]      inflight;
    logic [CNT_W-1:0]     fifoCount;
    logic [CNT_W:0]       creditsUsed;
    logic                 fifoFull;
    logic                 fifoEmpty;
    rspEntry_t            pushEntry;
    rspEntry_t            headEntry;

    // Registered counts only: a pop in this cycle does not return its credit until the next one.
    assign creditsUsed = (CNT_W+1)'(fifoCount) + (CNT_W+1)'(inflight);
    assign req_ready   = ~flush & (creditsUsed < (CNT_W+1)'(FIFO_DEPTH));
    assign fire        = req_valid & req_ready;

    assign mul_multiplicand = fire ? req_multiplicand : '0;
    assign mul_multiplier   = fire ? req_multiplier   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipeVld <= '0;
        end else if (flush) begin
            pipeVld <= '0;
        end else begin
            pipeVld[0] <= fire;
            for (int i = 1; i < MUL_LATENCY; i++) pipeVld[i] <= pipeVld[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LATENCY; i++) pipeTag[i] <= '0;
        end else begin
            pipeTag[0] <= req_tag;
            for (int i = 1; i < MUL_LATENCY; i++) pipeTag[i] <= pipeTag[i-1];
        end
    end

    // The last pipe stage lines up with the multiplier output for the same op.
    assign push               = pipeVld[MUL_LATENCY-1];
    assign pushEntry.result   = mul_result;
    assign pushEntry.overflow = mul_overflow;
    assign pushEntry.tag      = pipeTag[MUL_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else begin
            case ({fire, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign pop = rsp_valid & rsp_ready;

    mul_issue_fifo #(
        .WIDTH ($bits(rspEntry_t)),
        .DEPTH (FIFO_DEPTH)
    ) uRspFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .push    (push),
        .pushDat (pushEntry),
        .pop     (pop),
        .headDat (headEntry),
        .count   (fifoCount),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    assign rsp_valid    = ~fifoEmpty;
    assign rsp_result   = headEntry.result;
    assign rsp_overflow = headEntry.overflow;
    assign rsp_tag      = headEntry.tag;

`ifdef MUL_ISSUE_CTRL_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            stat_issued <= stat_issued + 32'(fire);
            stat_stall  <= stat_stall + 32'(req_valid & ~req_ready);
        end
    end
`endif
endmodule
